// File: rtl/signed_or_unsigned_div_pkg.sv
// Shared types and sizing helpers for the signed/unsigned restoring divider.
package signed_or_unsigned_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step counter must hold the value n, so it needs clog2(n+1) bits.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   prem        : current partial remainder (n+1 bits)
//   dvd         : dividend shift register; quotient bits enter at the LSB
//   dvs         : divisor magnitude
//   prem_next_c : partial remainder after the shift and trial subtract
//   dvd_next_c  : shift register with the new quotient bit appended
module div_step #(
    parameter int unsigned n = 8
) (
    input  logic [n:0]   prem,
    input  logic [n-1:0] dvd,
    input  logic [n-1:0] dvs,
    output logic [n:0]   prem_next_c,
    output logic [n-1:0] dvd_next_c
);

    logic [n+1:0] shifted;
    logic [n:0]   diff;
    logic         q_bit;

    // Shift the dividend MSB into the remainder, keep the difference only if it did not go negative.
    always_comb begin
        shifted     = {prem, dvd[n-1]};
        q_bit       = (shifted >= {2'b00, dvs});
        diff        = shifted[n:0] - {1'b0, dvs};
        prem_next_c = q_bit ? diff : shifted[n:0];
        dvd_next_c  = {dvd[n-2:0], q_bit};
    end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Sequential radix-2 restoring divider, signed or unsigned per operation.
//   clk, rst_n             : clock, asynchronous active-low reset
//   up_valid / up_ready    : operand handshake (a, b, signed_div); ready only in IDLE
//   down_valid / down_ready: result handshake (quot, rem, div_by_zero); valid only in DONE
// Division truncates toward zero; the remainder takes the dividend's sign.
// Divide by zero yields quot = all ones, rem = a, div_by_zero = 1.
module signed_or_unsigned_div
    import signed_or_unsigned_div_pkg::*;
#(
    parameter int unsigned n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signed_div,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [n-1:0] quot,
    output logic [n-1:0] rem,
    output logic         div_by_zero
);

    localparam int unsigned CW = cnt_width(n);

    div_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n:0]   prem_q, prem_d;
    logic [n-1:0] dvd_q, dvd_d;
    logic [n-1:0] dvs_q, dvs_d;
    logic         neg_quot_q, neg_quot_d;
    logic         neg_rem_q, neg_rem_d;
    logic         dz_q, dz_d;

    logic [n-1:0] quot_d, rem_d;
    logic         div_by_zero_d, up_ready_d, down_valid_d;

    logic         a_neg_c, b_neg_c;
    logic [n-1:0] a_mag_c, b_mag_c;
    logic [n:0]   prem_next_c;
    logic [n-1:0] dvd_next_c;

    div_step #(.n(n)) u_step (
        .prem        (prem_q),
        .dvd         (dvd_q),
        .dvs         (dvs_q),
        .prem_next_c (prem_next_c),
        .dvd_next_c  (dvd_next_c)
    );

    // Operand magnitudes; |-2^(n-1)| = 2^(n-1) still fits in n unsigned bits.
    always_comb begin
        a_neg_c = signed_div & a[n-1];
        b_neg_c = signed_div & b[n-1];
        a_mag_c = a_neg_c ? (~a + n'(1)) : a;
        b_mag_c = b_neg_c ? (~b + n'(1)) : b;
    end

    // Next-state and datapath/output next values.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prem_d        = prem_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        neg_quot_d    = neg_quot_q;
        neg_rem_d     = neg_rem_q;
        dz_d          = dz_q;
        quot_d        = quot;
        rem_d         = rem;
        div_by_zero_d = div_by_zero;
        up_ready_d    = up_ready;
        down_valid_d  = down_valid;

        case (state_q)
            IDLE: begin
                if (up_valid) begin
                    prem_d     = '0;
                    dvd_d      = a_mag_c;
                    dvs_d      = b_mag_c;
                    neg_rem_d  = a_neg_c;
                    neg_quot_d = a_neg_c ^ b_neg_c;
                    dz_d       = (b == '0);
                    cnt_d      = CW'(n);
                    up_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                prem_d = prem_next_c;
                dvd_d  = dvd_next_c;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // With a zero divisor every trial succeeds, so the remainder is |a| and
                    // re-applying the dividend sign returns a unchanged.
                    quot_d        = dz_q ? '1 :
                                    (neg_quot_q ? (~dvd_next_c + n'(1)) : dvd_next_c);
                    rem_d         = neg_rem_q ? (~prem_next_c[n-1:0] + n'(1)) : prem_next_c[n-1:0];
                    div_by_zero_d = dz_q;
                    down_valid_d  = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (down_ready) begin
                    down_valid_d = 1'b0;
                    up_ready_d   = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                down_valid_d = 1'b0;
                up_ready_d   = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            up_ready    <= 1'b1;
            down_valid  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            quot        <= quot_d;
            rem         <= rem_d;
            div_by_zero <= div_by_zero_d;
            up_ready    <= up_ready_d;
            down_valid  <= down_valid_d;
        end
    end

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Directed bench for signed_or_unsigned_div (n = 8).
module tb_signed_or_unsigned_div;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst_n;
    logic         up_valid;
    logic         up_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         signed_div;
    logic         down_valid;
    logic         down_ready;
    logic [N-1:0] quot;
    logic [N-1:0] rem;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    signed_or_unsigned_div #(.n(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid    (up_valid),
        .up_ready    (up_ready),
        .a           (a),
        .b           (b),
        .signed_div  (signed_div),
        .down_valid  (down_valid),
        .down_ready  (down_ready),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Wait for up_ready within a bound, then present operands for one cycle.
    task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic ts, input string tag);
        int w;
        w = 0;
        while (!up_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_up_ready"}, 32'(up_ready), 32'd1);
        a          = ta;
        b          = tb_v;
        signed_div = ts;
        up_valid   = 1'b1;
        @(negedge clk);
        up_valid   = 1'b0;
        a          = N'($urandom);
        b          = N'($urandom);
        signed_div = 1'($urandom);
        check({tag, "_busy"}, 32'(up_ready), 32'd0);
    endtask

    // Full operation: latency, result, optional DONE backpressure, release.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic ts,
                          input logic [N-1:0] eq, input logic [N-1:0] er, input logic edz,
                          input int hold, input string tag);
        int lat;
        down_ready = 1'b0;
        issue(ta, tb_v, ts, tag);
        lat = 1;
        while (!down_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(N + 1));
        check({tag, "_quot"}, 32'(quot), 32'(eq));
        check({tag, "_rem"}, 32'(rem), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        for (int i = 0; i < hold; i++) begin
            a        = N'($urandom);
            b        = N'($urandom);
            up_valid = ~up_valid;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(down_valid), 32'd1);
            check({tag, "_hold_quot"}, 32'(quot), 32'(eq));
            check({tag, "_hold_rem"}, 32'(rem), 32'(er));
            check({tag, "_hold_dz"}, 32'(div_by_zero), 32'(edz));
            check({tag, "_hold_ready"}, 32'(up_ready), 32'd0);
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        @(negedge clk);
        down_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(down_valid), 32'd0);
        check({tag, "_rel_ready"}, 32'(up_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        up_valid   = 1'b0;
        a          = '0;
        b          = '0;
        signed_div = 1'b0;
        down_ready = 1'b0;
        #12;
        check("rst_valid", 32'(down_valid), 32'd0);
        check("rst_quot", 32'(quot), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_up_ready", 32'(up_ready), 32'd1);

        //     a      b      sgn   quot   rem    dz    hold
        run_op(8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 1'b0, 0, "u_f9_2");
        run_op(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 0, "s_m7_2");
        run_op(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 0, "s_ovf");
        run_op(8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 0, "u_80_ff");
        run_op(8'h2A, 8'h00, 1'b1, 8'hFF, 8'h2A, 1'b1, 0, "s_dz");
        run_op(8'h2A, 8'h00, 1'b0, 8'hFF, 8'h2A, 1'b1, 0, "u_dz");
        run_op(8'hD6, 8'h00, 1'b1, 8'hFF, 8'hD6, 1'b1, 0, "s_neg_dz");
        run_op(8'h64, 8'hF7, 1'b1, 8'hF5, 8'h01, 1'b0, 0, "s_100_m9");
        run_op(8'h9C, 8'hF7, 1'b1, 8'h0B, 8'hFF, 1'b0, 0, "s_m100_m9");
        run_op(8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 0, "u_ff_1");
        run_op(8'h05, 8'h07, 1'b0, 8'h00, 8'h05, 1'b0, 0, "u_5_7");
        run_op(8'h64, 8'h09, 1'b0, 8'h0B, 8'h01, 1'b0, 5, "bp_100_9");

        // Abort mid-calculation with four steps still to go.
        issue(8'hF9, 8'h02, 1'b0, "abort");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(down_valid), 32'd0);
        check("abort_quot", 32'(quot), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("abort_no_result", 32'(down_valid), 32'd0);
        end
        run_op(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 0, "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
